// File: rtl/picture_loader_if.sv
// Pixel stream into the picture loader: valid/ready handshake with a frame-end marker.
interface picture_loader_if #(
  parameter int unsigned PIX_W = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;
  logic             s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/picture_loader.sv
// Loads one frame of 8-bit pixels into the network database, starts inference and
// reports the resulting digit, with frame-length checking and a hung-inference watchdog.
module picture_loader #(
  parameter int unsigned SIZE_1       = 11,
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned PICTURE_SIZE = 28,
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned TIMEOUT_W    = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  picture_loader_if.slave       pix,
  output logic                  we_database,
  output logic [SIZE_1-1:0]     dp_database,
  output logic [ADDR_W-1:0]     address_p_database,
  output logic                  GO,
  input  logic                  STOP,
  input  logic [3:0]            RESULT,
  output logic                  res_valid,
  output logic [3:0]            res_digit,
  output logic                  frame_err,
  output logic                  timeout,
  output logic                  busy
);
  localparam int unsigned N    = PICTURE_SIZE * PICTURE_SIZE;
  localparam int unsigned IdxW = $clog2(N);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [2:0] {
    StLoad, StDrain, StGoP, StWaitClr, StWaitDone, StReport
  } state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  we_q, we_d;
  logic [SIZE_1-1:0]     dp_q, dp_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  go_q, go_d;
  logic                  res_valid_q, res_valid_d;
  logic [3:0]            res_digit_q, res_digit_d;
  logic                  frame_err_q, frame_err_d;
  logic                  timeout_q, timeout_d;
  logic [TIMEOUT_W-1:0]  wd_q, wd_d;

  logic xfer;
  logic wd_max;

  assign pix.s_ready = (state_q == StLoad) || (state_q == StDrain);
  assign xfer        = pix.s_valid && pix.s_ready;
  assign wd_max      = &wd_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    we_d        = 1'b0;
    dp_d        = dp_q;
    addr_d      = addr_q;
    go_d        = 1'b0;
    res_valid_d = 1'b0;
    res_digit_d = res_digit_q;
    frame_err_d = 1'b0;
    timeout_d   = 1'b0;
    wd_d        = wd_q;
    case (state_q)
      StLoad: begin
        if (xfer) begin
          we_d   = 1'b1;
          // Unsigned pixel becomes pixel/256 in signed Q0.(SIZE_1-1).
          dp_d   = SIZE_1'(pix.s_data) << (SIZE_1 - 1 - PIX_W);
          addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
          idx_d  = idx_q + IdxW'(1);
          if (idx_q == LastIdx) begin
            idx_d = '0;
            if (pix.s_last) begin
              state_d = StGoP;
            end else begin
              frame_err_d = 1'b1;
              state_d     = StDrain;
            end
          end else if (pix.s_last) begin
            frame_err_d = 1'b1;
            idx_d       = '0;
          end
        end
      end
      StDrain: begin
        if (xfer && pix.s_last) begin
          state_d = StLoad;
          idx_d   = '0;
        end
      end
      StGoP: begin
        go_d    = 1'b1;
        wd_d    = '0;
        state_d = StWaitClr;
      end
      StWaitClr, StWaitDone: begin
        wd_d = wd_max ? wd_q : wd_q + TIMEOUT_W'(1);
        if (wd_max) begin
          timeout_d   = 1'b1;
          res_valid_d = 1'b1;
          res_digit_d = 4'hF;
          state_d     = StLoad;
        end else if (state_q == StWaitClr) begin
          // Only a clean 0 counts as the network having seen GO.
          if (STOP == 1'b0) state_d = StWaitDone;
        end else if (STOP == 1'b1) begin
          res_digit_d = RESULT;
          res_valid_d = 1'b1;
          state_d     = StReport;
        end
      end
      StReport: state_d = StLoad;
      default:  state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      idx_q       <= '0;
      we_q        <= 1'b0;
      dp_q        <= '0;
      addr_q      <= ADDR_W'(BASE_ADDR);
      go_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_digit_q <= 4'hF;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      dp_q        <= dp_d;
      addr_q      <= addr_d;
      go_q        <= go_d;
      res_valid_q <= res_valid_d;
      res_digit_q <= res_digit_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
      wd_q        <= wd_d;
    end
  end

  assign we_database        = we_q;
  assign dp_database        = dp_q;
  assign address_p_database = addr_q;
  assign GO                 = go_q;
  assign res_valid          = res_valid_q;
  assign res_digit          = res_digit_q;
  assign frame_err          = frame_err_q;
  assign timeout            = timeout_q;
  assign busy               = (state_q != StLoad);

endmodule
